codec_cfg_seq: RTL and testbench
================================

Name: codec_cfg_seq

Overview:
Power-up configuration sequencer for the audio codec. Walks a fixed table of 10 codec register writes (9-bit data, 7-bit register address) and hands each one to the shared I2C byte master as a two-byte write. Selects the sampling-control word from the WAV sampling rate, retries NACKed writes, and reports done/error to the top-level player FSM.

Parameters:
DEV_ADDR, 7'h1A, 7-bit I2C device address of the codec.
MAX_RETRY, 3, extra attempts per write after a NACK before error.
GAP_CYCLES, 1000, idle clk cycles between consecutive writes. Must be at least 1. Counter width is $clog2(GAP_CYCLES+1).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cfg_start_i  input  1  one-cycle pulse that starts a full configuration run
wav_info_sampling_rate_i  input  32  sampling rate in Hz; sampled at start
i2c_cmd_valid_o  output  1  write command valid
i2c_cmd_ready_i  input  1  I2C master accepts the command
i2c_dev_addr_o  output  7  device address, always DEV_ADDR
i2c_data_o  output  16  {reg_addr[6:0], reg_data[8:0]}; MSB byte is sent first
i2c_done_i  input  1  one-cycle pulse: transaction finished
i2c_nack_i  input  1  qualifies i2c_done_i: a NACK occurred
cfg_busy_o  output  1  high from start until DONE or ERROR
cfg_done_o  output  1  level; configuration complete
cfg_error_o  output  1  level; retries exhausted
cfg_rate_unsupported_o  output  1  the latched rate is not in the rate table
cfg_index_o  output  4  index of the current or failing table entry

Behaviour:
- Reset values: all outputs 0. State is IDLE.
- Write table, in index order, as (register, data):
  - 0: R15 = 0x000 (reset)
  - 1: R6 = 0x010
  - 2: R0 = 0x097
  - 3: R1 = 0x097
  - 4: R2 = 0x079
  - 5: R3 = 0x079
  - 6: R4 = 0x012
  - 7: R5 = 0x000
  - 8: R7 = 0x002 (I2S, 16-bit, slave)
  - 9: R9 = 0x001 (active)
- Entry 8 is followed by R8 = rate word, so the R8 write is slot 9 and R9 is slot 10. The run is 11 writes, with cfg_index_o running 0..10.
- Rate word (exact compare against the value latched at start):
  - 48000 -> 0x000
  - 32000 -> 0x018
  - 8000 -> 0x00C
  - 96000 -> 0x01C
  - any other value -> 0x000, and cfg_rate_unsupported_o = 1 until the next start.
- States:
  - IDLE: on cfg_start_i, latch the rate, idx = 0, retry = 0, clear done/error/unsupported. Go to ISSUE. cfg_busy_o = 1 from the cycle after the pulse.
  - ISSUE: i2c_cmd_valid_o = 1, data stable. On valid && ready, go to WAIT. Valid drops the next cycle.
  - WAIT: on i2c_done_i with !i2c_nack_i, go to GAP (idx == 10 goes to DONE instead).
  - WAIT, NACK case: on i2c_done_i with i2c_nack_i, if retry < MAX_RETRY then retry++ and go to GAP with the same idx. Otherwise go to ERROR.
  - GAP: count GAP_CYCLES, then go to ISSUE. idx++ and retry = 0 only if the last write was ACKed.
  - DONE: cfg_done_o = 1 and busy = 0. Return to IDLE behaviour; a new cfg_start_i restarts from idx 0.
  - ERROR: cfg_error_o = 1 and busy = 0. cfg_index_o holds the failing idx. cfg_start_i restarts.
- cfg_start_i while busy is ignored.
- i2c_done_i outside WAIT is ignored.
- i2c_cmd_ready_i can be asserted in the same cycle as valid rises; the minimum ISSUE dwell is 1 cycle.
- Asynchronous rst at any point returns to IDLE with outputs 0. The I2C master is reset by the same rst.
- Command rate: at most one command in flight.

Optional Feature:
CODEC_CFG_RECONFIG_EN:
- Defined:
  - In DONE, the block compares wav_info_sampling_rate_i with the latched rate every cycle.
  - On a mismatch it relatches the rate and runs a short sequence: R9 = 0x000, R8 = new rate word, R9 = 0x001.
  - cfg_index_o shows 11, 12 and 13 for these three writes, with the same retry, gap and error rules.
  - cfg_done_o drops during the sequence and rises again when it completes.
- Undefined: rate changes after DONE have no effect until the next cfg_start_i.

Decomposition:
- Shared package/include (beside buffer_consts.v), codec_consts.v:
  - register address constants R0..R15
  - table data words
  - rate words and rate Hz constants
  - CFG_LAST_IDX
  - state encodings
- Sub-module codec_cfg_rom: combinational idx + rate -> 16-bit command word plus an unsupported flag. The sequencer holds only the FSM, counters and handshake.

Test Plan:
- Rate 48000, I2C model always ACKs with ready=1 and done 5 cycles after accept: 11 commands in order, slot 9 data = 0x1000, slot 10 = 0x1201. cfg_done_o = 1, at least 1000 cycles of gap between commands.
- Rate 44100: slot 9 data = 0x1000, cfg_rate_unsupported_o = 1, and cfg_done_o still asserts.
- NACK idx 4 twice, then ACK: idx 4 is issued 3 times, run completes, cfg_error_o = 0.
- NACK idx 6 always (MAX_RETRY = 3): 4 attempts, then cfg_error_o = 1, cfg_index_o = 6, busy = 0. A new cfg_start_i restarts at idx 0.
- rst asserted while in WAIT at idx 5: outputs go to 0 that cycle (async). A start after release begins at idx 0 with R15.
- With CODEC_CFG_RECONFIG_EN, rate changes 48000 -> 32000 after DONE: exactly 3 commands 0x1200, 0x1018, 0x1201, then cfg_done_o = 1 again. Without the macro, no commands are issued.

Source files
------------

// File: rtl/codec_cfg_seq_pkg.sv
// codec_cfg_seq_pkg
//   Shared constants for the codec power-up configuration sequencer:
//   codec register addresses, table data words, sampling-rate words and
//   their Hz values, table index limits and the sequencer state encoding.
//   No ports; imported by codec_cfg_rom and codec_cfg_seq.
//   Optional feature macro: CODEC_CFG_RECONFIG_EN (see codec_cfg_seq).
package codec_cfg_seq_pkg;

   // codec register addresses
   localparam logic [6:0] R0  = 7'd0;
   localparam logic [6:0] R1  = 7'd1;
   localparam logic [6:0] R2  = 7'd2;
   localparam logic [6:0] R3  = 7'd3;
   localparam logic [6:0] R4  = 7'd4;
   localparam logic [6:0] R5  = 7'd5;
   localparam logic [6:0] R6  = 7'd6;
   localparam logic [6:0] R7  = 7'd7;
   localparam logic [6:0] R8  = 7'd8;
   localparam logic [6:0] R9  = 7'd9;
   localparam logic [6:0] R10 = 7'd10;
   localparam logic [6:0] R11 = 7'd11;
   localparam logic [6:0] R12 = 7'd12;
   localparam logic [6:0] R13 = 7'd13;
   localparam logic [6:0] R14 = 7'd14;
   localparam logic [6:0] R15 = 7'd15;

   // table data words
   localparam logic [8:0] D_RESET    = 9'h000;  // R15: codec soft reset
   localparam logic [8:0] D_PWR      = 9'h010;  // R6 : power down control
   localparam logic [8:0] D_LLIN     = 9'h097;  // R0 : left line in
   localparam logic [8:0] D_RLIN     = 9'h097;  // R1 : right line in
   localparam logic [8:0] D_LHP      = 9'h079;  // R2 : left headphone
   localparam logic [8:0] D_RHP      = 9'h079;  // R3 : right headphone
   localparam logic [8:0] D_APATH    = 9'h012;  // R4 : analog path
   localparam logic [8:0] D_DPATH    = 9'h000;  // R5 : digital path
   localparam logic [8:0] D_DAIF     = 9'h002;  // R7 : I2S, 16-bit, slave
   localparam logic [8:0] D_ACTIVE   = 9'h001;  // R9 : interface active
   localparam logic [8:0] D_INACTIVE = 9'h000;  // R9 : interface inactive

   // sampling rates and their R8 words
   localparam logic [31:0] RATE_48K_HZ = 32'd48000;
   localparam logic [31:0] RATE_32K_HZ = 32'd32000;
   localparam logic [31:0] RATE_8K_HZ  = 32'd8000;
   localparam logic [31:0] RATE_96K_HZ = 32'd96000;
   localparam logic [8:0]  RW_48K      = 9'h000;
   localparam logic [8:0]  RW_32K      = 9'h018;
   localparam logic [8:0]  RW_8K       = 9'h00C;
   localparam logic [8:0]  RW_96K      = 9'h01C;

   // slot indices: 0..10 full run, 11..13 rate-change sequence
   localparam logic [3:0] CFG_RATE_IDX    = 4'd9;
   localparam logic [3:0] CFG_LAST_IDX    = 4'd10;
   localparam logic [3:0] RECFG_FIRST_IDX = 4'd11;
   localparam logic [3:0] RECFG_LAST_IDX  = 4'd13;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_GAP,
      ST_DONE,
      ST_ERROR
   } cfg_state_t;

   typedef struct packed {
      logic       unsupported;
      logic [8:0] word;
   } rate_sel_t;

   function automatic rate_sel_t rate_lookup(input logic [31:0] hz);
      rate_sel_t r;
      r.unsupported = 1'b0;
      case (hz)
         RATE_48K_HZ: r.word = RW_48K;
         RATE_32K_HZ: r.word = RW_32K;
         RATE_8K_HZ:  r.word = RW_8K;
         RATE_96K_HZ: r.word = RW_96K;
         default: begin
            r.word        = RW_48K;
            r.unsupported = 1'b1;
         end
      endcase
      return r;
   endfunction

   // register address goes in the MSB byte so it is sent first
   function automatic logic [15:0] cmd_word(input logic [6:0] ra, input logic [8:0] rd);
      return {ra, rd};
   endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom
//   Combinational command table: slot index plus latched sampling rate in,
//   16-bit I2C write word {reg_addr[6:0], reg_data[8:0]} out.
//   Ports:
//     idx         in   4  slot index (0..13)
//     rate        in  32  latched sampling rate in Hz
//     cmd         out 16  command word for the slot
//     unsupported out  1  rate is not one of the known rates
module codec_cfg_rom
   import codec_cfg_seq_pkg::*;
(
   input  logic [3:0]  idx,
   input  logic [31:0] rate,
   output logic [15:0] cmd,
   output logic        unsupported
);

   rate_sel_t sel;

   always_comb begin
      sel         = rate_lookup(rate);
      unsupported = sel.unsupported;
      case (idx)
         4'd0:    cmd = cmd_word(R15, D_RESET);
         4'd1:    cmd = cmd_word(R6,  D_PWR);
         4'd2:    cmd = cmd_word(R0,  D_LLIN);
         4'd3:    cmd = cmd_word(R1,  D_RLIN);
         4'd4:    cmd = cmd_word(R2,  D_LHP);
         4'd5:    cmd = cmd_word(R3,  D_RHP);
         4'd6:    cmd = cmd_word(R4,  D_APATH);
         4'd7:    cmd = cmd_word(R5,  D_DPATH);
         4'd8:    cmd = cmd_word(R7,  D_DAIF);
         4'd9:    cmd = cmd_word(R8,  sel.word);
         4'd10:   cmd = cmd_word(R9,  D_ACTIVE);
         // rate-change sequence: deactivate, new rate, reactivate
         4'd11:   cmd = cmd_word(R9,  D_INACTIVE);
         4'd12:   cmd = cmd_word(R8,  sel.word);
         4'd13:   cmd = cmd_word(R9,  D_ACTIVE);
         default: cmd = cmd_word(R9,  D_ACTIVE);
      endcase
   end

endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq
//   Power-up configuration sequencer for the audio codec. Walks the command
//   table in codec_cfg_rom and hands each entry to the shared I2C byte
//   master as a two-byte write, one command in flight at a time, with an
//   idle gap between writes and bounded retries on NACK.
//   Optional feature: define CODEC_CFG_RECONFIG_EN to rerun the R9/R8/R9
//   rate-change sequence whenever the sampling rate input changes in DONE.
//   Ports:
//     clk, rst                  clock, async active-high reset
//     cfg_start_i               pulse: start a full run (ignored while busy)
//     wav_info_sampling_rate_i  sampling rate in Hz, latched at start
//     i2c_cmd_valid_o/ready_i   command handshake to the I2C master
//     i2c_dev_addr_o            codec device address
//     i2c_data_o                {reg_addr, reg_data}, zero when not valid
//     i2c_done_i, i2c_nack_i    transaction finished / NACK qualifier
//     cfg_busy_o, cfg_done_o, cfg_error_o  run status
//     cfg_rate_unsupported_o    latched rate not in the rate table
//     cfg_index_o               current or failing slot index
module codec_cfg_seq
   import codec_cfg_seq_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = 7'h1A,
   parameter int         MAX_RETRY  = 3,
   parameter int         GAP_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start_i,
   input  logic [31:0] wav_info_sampling_rate_i,
   output logic        i2c_cmd_valid_o,
   input  logic        i2c_cmd_ready_i,
   output logic [6:0]  i2c_dev_addr_o,
   output logic [15:0] i2c_data_o,
   input  logic        i2c_done_i,
   input  logic        i2c_nack_i,
   output logic        cfg_busy_o,
   output logic        cfg_done_o,
   output logic        cfg_error_o,
   output logic        cfg_rate_unsupported_o,
   output logic [3:0]  cfg_index_o
);

   localparam int GW  = $clog2(GAP_CYCLES + 1);
   localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [RTW-1:0] RETRY_LIM = RTW'(MAX_RETRY);

   cfg_state_t     state, state_nxt;
   logic [3:0]     idx;
   logic [RTW-1:0] retry;
   logic [GW-1:0]  gap_cnt;
   logic [31:0]    rate;
   logic           have_rate;
   logic           acked;

   logic           start_run, reconfig, ack_ok, nack_retry, gap_end;
   logic [15:0]    rom_cmd;
   logic           rom_unsup;

   codec_cfg_rom u_rom (
      .idx         (idx),
      .rate        (rate),
      .cmd         (rom_cmd),
      .unsupported (rom_unsup)
   );

   always_comb begin
      state_nxt  = state;
      start_run  = 1'b0;
      reconfig   = 1'b0;
      ack_ok     = 1'b0;
      nack_retry = 1'b0;
      gap_end    = 1'b0;
      case (state)
         ST_IDLE, ST_ERROR: begin
            if (cfg_start_i) begin
               start_run = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_DONE: begin
            if (cfg_start_i) begin
               start_run = 1'b1;
               state_nxt = ST_ISSUE;
            end
`ifdef CODEC_CFG_RECONFIG_EN
            else if (wav_info_sampling_rate_i != rate) begin
               reconfig  = 1'b1;
               state_nxt = ST_ISSUE;
            end
`endif
         end
         ST_ISSUE: begin
            if (i2c_cmd_ready_i) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (i2c_done_i) begin
               if (!i2c_nack_i) begin
                  ack_ok    = 1'b1;
                  state_nxt = (idx == CFG_LAST_IDX || idx == RECFG_LAST_IDX) ? ST_DONE : ST_GAP;
               end else if (retry < RETRY_LIM) begin
                  nack_retry = 1'b1;
                  state_nxt  = ST_GAP;
               end else begin
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               gap_end   = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         retry     <= '0;
         gap_cnt   <= '0;
         rate      <= '0;
         have_rate <= 1'b0;
         acked     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_run) begin
            rate      <= wav_info_sampling_rate_i;
            have_rate <= 1'b1;
            idx       <= '0;
            retry     <= '0;
            acked     <= 1'b0;
         end
         if (reconfig) begin
            rate  <= wav_info_sampling_rate_i;
            idx   <= RECFG_FIRST_IDX;
            retry <= '0;
            acked <= 1'b0;
         end
         if (ack_ok) acked <= 1'b1;
         if (nack_retry) begin
            retry <= retry + RTW'(1);
            acked <= 1'b0;
         end
         // gap counter restarts every time a transaction is waited on
         if (state == ST_WAIT)     gap_cnt <= '0;
         else if (state == ST_GAP) gap_cnt <= gap_cnt + GW'(1);
         // a NACKed slot is reissued as-is; only an ACK advances the table
         if (gap_end && acked) begin
            idx   <= idx + 4'd1;
            retry <= '0;
         end
      end
   end

   assign i2c_cmd_valid_o        = (state == ST_ISSUE);
   assign i2c_dev_addr_o         = DEV_ADDR;
   assign i2c_data_o             = i2c_cmd_valid_o ? rom_cmd : 16'h0000;
   assign cfg_busy_o             = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_GAP);
   assign cfg_done_o             = (state == ST_DONE);
   assign cfg_error_o            = (state == ST_ERROR);
   // the latched-rate register is meaningless until the first start
   assign cfg_rate_unsupported_o = have_rate & rom_unsup;
   assign cfg_index_o            = idx;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq
//   Self-checking bench for codec_cfg_seq with default parameters. An I2C
//   master model accepts every command (ready=1), answers 5 cycles later and
//   NACKs a chosen slot a chosen number of times. Expected commands are
//   queued when each run is started and popped as the DUT issues them.
module tb_codec_cfg_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start_i;
   logic [31:0] wav_info_sampling_rate_i;
   logic        i2c_cmd_valid_o;
   logic        i2c_cmd_ready_i;
   logic [6:0]  i2c_dev_addr_o;
   logic [15:0] i2c_data_o;
   logic        i2c_done_i;
   logic        i2c_nack_i;
   logic        cfg_busy_o;
   logic        cfg_done_o;
   logic        cfg_error_o;
   logic        cfg_rate_unsupported_o;
   logic [3:0]  cfg_index_o;

   always #5 clk = ~clk;

   codec_cfg_seq dut (
      .clk                      (clk),
      .rst                      (rst),
      .cfg_start_i              (cfg_start_i),
      .wav_info_sampling_rate_i (wav_info_sampling_rate_i),
      .i2c_cmd_valid_o          (i2c_cmd_valid_o),
      .i2c_cmd_ready_i          (i2c_cmd_ready_i),
      .i2c_dev_addr_o           (i2c_dev_addr_o),
      .i2c_data_o               (i2c_data_o),
      .i2c_done_i               (i2c_done_i),
      .i2c_nack_i               (i2c_nack_i),
      .cfg_busy_o               (cfg_busy_o),
      .cfg_done_o               (cfg_done_o),
      .cfg_error_o              (cfg_error_o),
      .cfg_rate_unsupported_o   (cfg_rate_unsupported_o),
      .cfg_index_o              (cfg_index_o)
   );

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   cmd_cnt = 0;
   int   nack_idx = -1;
   int   nack_left = 0;
   bit   extra_done = 1'b0;
   bit   has_prev = 1'b0;
   int   last_done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] exp_rate(input logic [31:0] hz);
      case (hz)
         32'd48000: return 9'h000;
         32'd32000: return 9'h018;
         32'd8000:  return 9'h00C;
         32'd96000: return 9'h01C;
         default:   return 9'h000;
      endcase
   endfunction

   function automatic logic [15:0] exp_word(input int i, input logic [8:0] rw);
      case (i)
         0:  return 16'h1E00;
         1:  return 16'h0C10;
         2:  return 16'h0097;
         3:  return 16'h0297;
         4:  return 16'h0479;
         5:  return 16'h0679;
         6:  return 16'h0812;
         7:  return 16'h0A00;
         8:  return 16'h0E02;
         9:  return 16'h1000 | {7'd0, rw};
         default: return 16'h1201;
      endcase
   endfunction

   task automatic push(input int i, input logic [15:0] d);
      exp_t e;
      e.idx  = 4'(i);
      e.data = d;
      sb.push_back(e);
   endtask

   // full run; slot nidx is NACKed ntimes (above 3 means it errors out)
   task automatic push_run(input logic [31:0] hz, input int nidx, input int ntimes);
      int reps;
      for (int i = 0; i <= 10; i++) begin
         reps = (i == nidx) ? ((ntimes > 3) ? 4 : ntimes + 1) : 1;
         for (int r = 0; r < reps; r++) push(i, exp_word(i, exp_rate(hz)));
         if (i == nidx && ntimes > 3) return;
      end
   endtask

   task automatic start_run(input logic [31:0] hz);
      @(negedge clk);
      wav_info_sampling_rate_i = hz;
      cfg_start_i = 1'b1;
      has_prev = 1'b0;
      @(negedge clk);
      cfg_start_i = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      while (!(cfg_done_o || cfg_error_o) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_finished"}, 32'(n < budget), 1);
   endtask

   // I2C master model
   initial begin
      exp_t e;
      logic nk;
      i2c_done_i = 1'b0;
      i2c_nack_i = 1'b0;
      i2c_cmd_ready_i = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && i2c_cmd_valid_o && i2c_cmd_ready_i) begin
            cmd_cnt++;
            if (has_prev) chk("gap_cycles_ge_1000", 32'((cyc - last_done_cyc) >= 1000), 1);
            chk("cmd_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("cmd_idx", 32'(cfg_index_o), 32'(e.idx));
               chk("cmd_data", 32'(i2c_data_o), 32'(e.data));
               chk("cmd_dev", 32'(i2c_dev_addr_o), 32'h1A);
            end
            nk = (int'(cfg_index_o) == nack_idx) && (nack_left > 0);
            if (nk && nack_left < 100) nack_left--;
            repeat (5) @(negedge clk);
            i2c_done_i = 1'b1;
            i2c_nack_i = nk;
            @(negedge clk);
            i2c_done_i = 1'b0;
            i2c_nack_i = 1'b0;
            has_prev = 1'b1;
            last_done_cyc = cyc;
            if (extra_done) begin
               // stray done pulse while the sequencer sits in GAP/DONE
               repeat (50) @(negedge clk);
               i2c_done_i = 1'b1;
               @(negedge clk);
               i2c_done_i = 1'b0;
            end
         end
      end
   end

   initial begin
      int n;
      int cmd_before;
      rst = 1'b1;
      cfg_start_i = 1'b0;
      wav_info_sampling_rate_i = 32'd48000;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(i2c_cmd_valid_o), 0);
      chk("rst_data", 32'(i2c_data_o), 0);
      chk("rst_busy", 32'(cfg_busy_o), 0);
      chk("rst_done", 32'(cfg_done_o), 0);
      chk("rst_error", 32'(cfg_error_o), 0);
      chk("rst_unsup", 32'(cfg_rate_unsupported_o), 0);
      chk("rst_index", 32'(cfg_index_o), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // run 1: 48 kHz, all ACK, with a start pulse while busy
      push_run(32'd48000, -1, 0);
      start_run(32'd48000);
      chk("r1_busy_after_start", 32'(cfg_busy_o), 1);
      n = 0;
      while (cfg_index_o != 4'd3 && n < 5000) begin @(negedge clk); n++; end
      chk("r1_reach_idx3", 32'(n < 5000), 1);
      cfg_start_i = 1'b1;
      @(negedge clk);
      cfg_start_i = 1'b0;
      wait_end("r1", 15000);
      chk("r1_done", 32'(cfg_done_o), 1);
      chk("r1_error", 32'(cfg_error_o), 0);
      chk("r1_busy", 32'(cfg_busy_o), 0);
      chk("r1_unsup", 32'(cfg_rate_unsupported_o), 0);
      chk("r1_index", 32'(cfg_index_o), 10);
      chk("r1_sb_empty", 32'(sb.size()), 0);
      chk("r1_cmd_cnt", 32'(cmd_cnt), 11);

      // rate change while in DONE
      repeat (10) @(negedge clk);
      cmd_before = cmd_cnt;
      has_prev = 1'b0;
`ifdef CODEC_CFG_RECONFIG_EN
      push(11, 16'h1200);
      push(12, 16'h1018);
      push(13, 16'h1201);
      wav_info_sampling_rate_i = 32'd32000;
      n = 0;
      while (cfg_done_o && n < 10) begin @(negedge clk); n++; end
      chk("rc_done_drops", 32'(cfg_done_o), 0);
      wait_end("rc", 5000);
      chk("rc_done", 32'(cfg_done_o), 1);
      chk("rc_index", 32'(cfg_index_o), 13);
      chk("rc_cmds", 32'(cmd_cnt - cmd_before), 3);
      chk("rc_sb_empty", 32'(sb.size()), 0);
`else
      wav_info_sampling_rate_i = 32'd32000;
      repeat (3000) @(negedge clk);
      chk("rc_no_cmds", 32'(cmd_cnt - cmd_before), 0);
      chk("rc_done_held", 32'(cfg_done_o), 1);
      chk("rc_index_held", 32'(cfg_index_o), 10);
`endif
      repeat (10) @(negedge clk);

      // run 2: unsupported 44.1 kHz, stray done pulses in GAP
      extra_done = 1'b1;
      push_run(32'd44100, -1, 0);
      start_run(32'd44100);
      chk("r2_unsup_early", 32'(cfg_rate_unsupported_o), 1);
      wait_end("r2", 15000);
      chk("r2_done", 32'(cfg_done_o), 1);
      chk("r2_error", 32'(cfg_error_o), 0);
      chk("r2_unsup", 32'(cfg_rate_unsupported_o), 1);
      chk("r2_sb_empty", 32'(sb.size()), 0);
      repeat (100) @(negedge clk);
      extra_done = 1'b0;

      // run 3: slot 4 NACKed twice, then ACKed
      nack_idx = 4;
      nack_left = 2;
      push_run(32'd48000, 4, 2);
      start_run(32'd48000);
      chk("r3_unsup_cleared", 32'(cfg_rate_unsupported_o), 0);
      wait_end("r3", 20000);
      chk("r3_done", 32'(cfg_done_o), 1);
      chk("r3_error", 32'(cfg_error_o), 0);
      chk("r3_sb_empty", 32'(sb.size()), 0);
      repeat (10) @(negedge clk);

      // run 4: slot 6 always NACKed
      nack_idx = 6;
      nack_left = 100;
      push_run(32'd48000, 6, 100);
      start_run(32'd48000);
      wait_end("r4", 20000);
      chk("r4_error", 32'(cfg_error_o), 1);
      chk("r4_done", 32'(cfg_done_o), 0);
      chk("r4_busy", 32'(cfg_busy_o), 0);
      chk("r4_index", 32'(cfg_index_o), 6);
      chk("r4_sb_empty", 32'(sb.size()), 0);
      repeat (10) @(negedge clk);

      // restart after error, then async reset while waiting on slot 5
      nack_idx = -1;
      nack_left = 0;
      push_run(32'd48000, -1, 0);
      start_run(32'd48000);
      chk("r5_error_cleared", 32'(cfg_error_o), 0);
      n = 0;
      while (sb.size() > 5 && n < 8000) begin @(negedge clk); n++; end
      chk("r5_reach_idx5", 32'(n < 8000), 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 32'(i2c_cmd_valid_o), 0);
      chk("ar_data", 32'(i2c_data_o), 0);
      chk("ar_busy", 32'(cfg_busy_o), 0);
      chk("ar_done", 32'(cfg_done_o), 0);
      chk("ar_error", 32'(cfg_error_o), 0);
      chk("ar_index", 32'(cfg_index_o), 0);
      sb.delete();
      repeat (10) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // first command after reset must be slot 0, R15
      push(0, 16'h1E00);
      start_run(32'd48000);
      n = 0;
      while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
      chk("ar_first_cmd_seen", 32'(n < 100), 1);
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
